truth_table_scanner: RTL and testbench

//  Sequencer for a small combinational block under characterisation (e.g. the 3-input a/b/c -> s1 circuits).
//  On a start pulse it drives every input combination onto the block in binary order, holds each for DWELL cycles,

---
 rtl/truth_table_scanner_if.sv | 41 ++++
 rtl/truth_table_scanner.sv | 139 +++++++++++++
 tb/tb_truth_table_scanner.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: bundle between a truth-table scanner and its host / block-under-scan.
// Parameter: N_IN  width of the input vector; the table holds 2**N_IN bits.
// Signals:  start (host -> scanner), s1 (block output -> scanner),
//           vec, busy, done, tt, tt_valid (scanner -> environment),
//           expected (host -> scanner), mismatch, fail_idx (scanner -> host)
//           the last three exist only when EXPECT_CHECK_EN is defined.
// Modports: slave = scanner side, master = host / block side.
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic                   s1;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   tt;
    logic                   tt_valid;
`ifdef EXPECT_CHECK_EN
    logic [(1<<N_IN)-1:0]   expected;
    logic                   mismatch;
    logic [N_IN-1:0]        fail_idx;

    modport slave (
        input  start, s1, expected,
        output vec, busy, done, tt, tt_valid, mismatch, fail_idx
    );
    modport master (
        output start, s1, expected,
        input  vec, busy, done, tt, tt_valid, mismatch, fail_idx
    );
`else
    modport slave (
        input  start, s1,
        output vec, busy, done, tt, tt_valid
    );
    modport master (
        output start, s1,
        input  vec, busy, done, tt, tt_valid
    );
`endif
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks every input combination of a small combinational block in binary
// order, holds each for DWELL cycles, samples the block output and builds its truth table.
// Parameters: N_IN (1..6) vector width, DWELL (>=1) cycles per vector.
// Ports: clk, rst_n (synchronous, active-low) plus bus (truth_table_scanner_if.slave):
//   start in, s1 in, vec out, busy out, done out (1-cycle pulse), tt out, tt_valid out.
// Optional feature macro EXPECT_CHECK_EN: adds expected in, mismatch out, fail_idx out; the
//   reference table is latched on an accepted start and compared when the scan completes.
module truth_table_scanner #(
    parameter int N_IN  = 3,
    parameter int DWELL = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_scanner_if.slave bus
);
    localparam int TW = 1 << N_IN;
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TW - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    vec_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    tt_d[vec_q] = bus.s1;
                    if (vec_q == VEC_LAST) begin
                        // vec stays on the last combination; it is only cleared by the next start
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vec      = vec_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tt       = tt_q;
    assign bus.tt_valid = valid_q;

`ifdef EXPECT_CHECK_EN
    logic [TW-1:0]   exp_q, exp_d;
    logic            mis_q, mis_d;
    logic [N_IN-1:0] fidx_q, fidx_d;
    logic [TW-1:0]   diff;
    logic [N_IN-1:0] low;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q  <= '0;
            mis_q  <= 1'b0;
            fidx_q <= '0;
        end else begin
            exp_q  <= exp_d;
            mis_q  <= mis_d;
            fidx_q <= fidx_d;
        end
    end

    // compare against the table as it will be after this edge, so the last sample is included
    always_comb begin
        exp_d  = exp_q;
        mis_d  = mis_q;
        fidx_d = fidx_q;
        diff   = tt_d ^ exp_q;
        low    = '0;
        for (int k = TW - 1; k >= 0; k--) begin
            if (diff[k]) low = N_IN'(k);
        end
        if (state_q == IDLE && bus.start) begin
            exp_d  = bus.expected;
            mis_d  = 1'b0;
            fidx_d = '0;
        end else if (state_q == SCAN && state_d == DONE) begin
            mis_d  = |diff;
            fidx_d = low;
        end
    end

    assign bus.mismatch = mis_q;
    assign bus.fail_idx = fidx_q;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: two scanners (DWELL=1 and DWELL=3) run side by side against a
// cycle-position model; s1 carries the block function only on each model sample cycle and
// random noise otherwise, so sampling at the wrong cycle corrupts the table.
module tb_truth_table_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] func = 8'h00;
    logic [7:0] exp_in = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         busy_cnt [2];
    int         done_cnt [2];

    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(3)) bus0 ();
    truth_table_scanner_if #(.N_IN(3)) bus1 ();

    truth_table_scanner #(.N_IN(3), .DWELL(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    truth_table_scanner #(.N_IN(3), .DWELL(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // model state: position t counts cycles since the scan began
    logic       m_busy  [2] = '{1'b0, 1'b0};
    logic       m_done  [2] = '{1'b0, 1'b0};
    logic       m_valid [2] = '{1'b0, 1'b0};
    int         m_t     [2] = '{0, 0};
    logic [2:0] m_vec   [2] = '{3'd0, 3'd0};
    logic [7:0] m_tt    [2] = '{8'd0, 8'd0};
    logic [7:0] m_exp   [2] = '{8'd0, 8'd0};
    logic       m_mis   [2] = '{1'b0, 1'b0};
    logic [2:0] m_fidx  [2] = '{3'd0, 3'd0};
    logic       noise   [2] = '{1'b0, 1'b0};
    logic       samp    [2];

    function automatic int dw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    assign samp[0] = m_busy[0] && (m_t[0] % dw(0) == dw(0) - 1);
    assign samp[1] = m_busy[1] && (m_t[1] % dw(1) == dw(1) - 1);
    assign bus0.start = start;
    assign bus1.start = start;
    assign bus0.s1 = samp[0] ? func[m_vec[0]] : noise[0];
    assign bus1.s1 = samp[1] ? func[m_vec[1]] : noise[1];
`ifdef EXPECT_CHECK_EN
    assign bus0.expected = exp_in;
    assign bus1.expected = exp_in;
`endif

    logic [2:0] d_vec   [2];
    logic       d_busy  [2];
    logic       d_done  [2];
    logic [7:0] d_tt    [2];
    logic       d_valid [2];
    assign d_vec[0] = bus0.vec;       assign d_vec[1] = bus1.vec;
    assign d_busy[0] = bus0.busy;     assign d_busy[1] = bus1.busy;
    assign d_done[0] = bus0.done;     assign d_done[1] = bus1.done;
    assign d_tt[0] = bus0.tt;         assign d_tt[1] = bus1.tt;
    assign d_valid[0] = bus0.tt_valid; assign d_valid[1] = bus1.tt_valid;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int         d;
            automatic logic [7:0] ntt;
            automatic logic [7:0] diff;
            automatic logic       s;
            d   = dw(i);
            ntt = m_tt[i];
            s   = (i == 0) ? bus0.s1 : bus1.s1;
            if (!rst_n) begin
                m_busy[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
                m_valid[i] <= 1'b0;
                m_t[i]     <= 0;
                m_vec[i]   <= 3'd0;
                m_tt[i]    <= 8'd0;
                m_mis[i]   <= 1'b0;
                m_fidx[i]  <= 3'd0;
            end else if (m_busy[i]) begin
                if (m_t[i] % d == d - 1) ntt[m_t[i] / d] = s;
                m_tt[i] <= ntt;
                if (m_t[i] == 8 * d - 1) begin
                    diff       = ntt ^ m_exp[i];
                    m_busy[i]  <= 1'b0;
                    m_done[i]  <= 1'b1;
                    m_valid[i] <= 1'b1;
                    m_mis[i]   <= (diff != 8'd0);
                    m_fidx[i]  <= 3'($clog2(diff & (~diff + 8'd1)));
                end else begin
                    m_t[i]   <= m_t[i] + 1;
                    m_vec[i] <= 3'((m_t[i] + 1) / d);
                end
            end else if (m_done[i]) begin
                m_done[i] <= 1'b0;
            end else if (start) begin
                m_busy[i]  <= 1'b1;
                m_t[i]     <= 0;
                m_vec[i]   <= 3'd0;
                m_tt[i]    <= 8'd0;
                m_valid[i] <= 1'b0;
                m_exp[i]   <= exp_in;
                m_mis[i]   <= 1'b0;
                m_fidx[i]  <= 3'd0;
            end
        end
    end

    task automatic chk(input string n, input int i, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s[dwell%0d] got=%0h want=%0h at %0t", n, dw(i), a, e, $time);
        end
    endtask

    // one cycle: compare every DUT output with the model, then refresh noise
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("vec", i, 8'(d_vec[i]), 8'(m_vec[i]));
            chk("busy", i, 8'(d_busy[i]), 8'(m_busy[i]));
            chk("done", i, 8'(d_done[i]), 8'(m_done[i]));
            chk("tt", i, d_tt[i], m_tt[i]);
            chk("tt_valid", i, 8'(d_valid[i]), 8'(m_valid[i]));
`ifdef EXPECT_CHECK_EN
            chk("mismatch", i, 8'((i == 0) ? bus0.mismatch : bus1.mismatch), 8'(m_mis[i]));
            chk("fail_idx", i, 8'((i == 0) ? bus0.fail_idx : bus1.fail_idx), 8'(m_fidx[i]));
`endif
            busy_cnt[i] += int'(d_busy[i]);
            done_cnt[i] += int'(d_done[i]);
            noise[i] = 1'($urandom);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
        end
    endtask

    task automatic scan(input logic [7:0] f);
        func = f;
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
    endtask

    task automatic check_idle_zero(input string n);
        for (int i = 0; i < 2; i++) begin
            chk({n, "_vec"}, i, 8'(d_vec[i]), 8'd0);
            chk({n, "_busy"}, i, 8'(d_busy[i]), 8'd0);
            chk({n, "_done"}, i, 8'(d_done[i]), 8'd0);
            chk({n, "_tt"}, i, d_tt[i], 8'd0);
            chk({n, "_valid"}, i, 8'(d_valid[i]), 8'd0);
        end
    endtask

    initial begin
        int n;
        clear_counts();
        step();
        step();
        check_idle_zero("por");
        rst_n = 1'b1;

        // random activity, then a two-cycle reset
        repeat (20) begin
            start = 1'($urandom);
            func  = 8'($urandom);
            step();
        end
        start = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_idle_zero("rst2");
        rst_n = 1'b1;

        // (a&b)|c table, single start pulse
        scan(8'hEA);
        for (int i = 0; i < 2; i++) begin
            chk("tt_and_or", i, d_tt[i], 8'hEA);
            chk("model_and_or", i, m_tt[i], 8'hEA);
            chk("valid_after", i, 8'(d_valid[i]), 8'd1);
            chk("done_pulses", i, 8'(done_cnt[i]), 8'd1);
            chk("vec_hold_last", i, 8'(d_vec[i]), 8'd7);
        end
        chk("busy_cycles", 0, 8'(busy_cnt[0]), 8'd8);
        chk("busy_cycles", 1, 8'(busy_cnt[1]), 8'd24);

        // start held high: back-to-back scans
        func = 8'($urandom);
        clear_counts();
        start = 1'b1;
        repeat (30) step();
        start = 1'b0;
        repeat (30) step();
        chk("held_done_count", 0, 8'(done_cnt[0]), 8'd3);
        chk("held_done_count", 1, 8'(done_cnt[1]), 8'd2);

        // reset while the DWELL=1 scanner presents vector 4
        func = 8'hEA;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (d_vec[0] != 3'd4 && n < 20) begin
            step();
            n++;
        end
        chk("reach_vec4", 0, 8'(n < 20), 8'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle_zero("midscan_rst");
        clear_counts();
        repeat (10) step();
        chk("no_done_after_abort", 0, 8'(done_cnt[0]), 8'd0);
        chk("no_done_after_abort", 1, 8'(done_cnt[1]), 8'd0);

`ifdef EXPECT_CHECK_EN
        exp_in = 8'hEA;
        scan(8'h96);
        for (int i = 0; i < 2; i++) begin
            chk("tt_xor", i, d_tt[i], 8'h96);
            chk("xor_mismatch", i, 8'((i == 0) ? bus0.mismatch : bus1.mismatch), 8'd1);
            chk("xor_fail_idx", i, 8'((i == 0) ? bus0.fail_idx : bus1.fail_idx), 8'd2);
        end
        exp_in = 8'h96;
        scan(8'h96);
        for (int i = 0; i < 2; i++) begin
            chk("xor_match", i, 8'((i == 0) ? bus0.mismatch : bus1.mismatch), 8'd0);
        end
`endif

        // randomized traffic with occasional resets
        repeat (400) begin
            rst_n  = ($urandom_range(0, 99) >= 3);
            start  = ($urandom_range(0, 3) == 0);
            func   = 8'($urandom);
            exp_in = 8'($urandom);
            step();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (30) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
